// File: rtl/game_pkg.sv
// Shared widths, FSM encoding and angle helper for the enemy spawn path.
package game_pkg;
  localparam int COORD_W = 11;
  localparam int ANGLE_W = 4;
  localparam int SLOT_W  = 4;
  localparam int PER_W   = 8;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SELECT,
    ISSUE
  } spawn_state_t;

  // Never repeat the previous ring angle back-to-back.
  function automatic logic [ANGLE_W-1:0] next_angle(
    input logic [ANGLE_W-1:0] r,
    input logic [ANGLE_W-1:0] last
  );
    return (r == last) ? r + ANGLE_W'(1) : r;
  endfunction
endpackage

// File: rtl/slot_prienc.sv
// Lowest-free-slot finder over the enemy occupancy bitmap.
module slot_prienc
  import game_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]      bitmap_i,
  output logic [SLOT_W-1:0] free_idx_o,
  output logic              any_free_o
);
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!bitmap_i[i]) begin
        free_idx_o = SLOT_W'(i);
        any_free_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Paces enemy spawns on frame ticks, picks a ring angle and a free slot,
// and emits a one-cycle spawn event with the looked-up start position.
module enemy_spawn_scheduler
  import game_pkg::*;
#(
  parameter int MAX_ENEMIES  = 8,
  parameter int START_PERIOD = 60,
  parameter int MIN_PERIOD   = 15,
  parameter int RAMP_SPAWNS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   game_active,
  input  logic [ANGLE_W-1:0]     rand_angle,
  input  logic [COORD_W-1:0]     lut_x,
  input  logic [COORD_W-1:0]     lut_y,
  input  logic                   kill_valid,
  input  logic [SLOT_W-1:0]      kill_idx,
  output logic [ANGLE_W-1:0]     angle_sel,
  output logic                   spawn_valid,
  output logic [SLOT_W-1:0]      spawn_slot,
  output logic [COORD_W-1:0]     spawn_x,
  output logic [COORD_W-1:0]     spawn_y,
  output logic [MAX_ENEMIES-1:0] slot_active,
  output logic [CNT_W-1:0]       active_count
);
  spawn_state_t          state_q;
  logic [PER_W-1:0]      period_q;
  logic [PER_W-1:0]      frame_q;
  logic [PER_W-1:0]      ramp_q;
  logic                  due_q;
  logic [ANGLE_W-1:0]    last_q;
  logic [ANGLE_W-1:0]    angle_q;
  logic [SLOT_W-1:0]     slot_q;
  logic                  valid_q;
  logic [SLOT_W-1:0]     sslot_q;
  logic [COORD_W-1:0]    sx_q;
  logic [COORD_W-1:0]    sy_q;
  logic [MAX_ENEMIES-1:0] act_q;
  logic [MAX_ENEMIES-1:0] act_d;
  logic [MAX_ENEMIES-1:0] kill_m;
  logic [MAX_ENEMIES-1:0] set_m;
  logic [SLOT_W-1:0]     free_idx;
  logic                  any_free;

  slot_prienc #(.N(MAX_ENEMIES)) u_prienc (
    .bitmap_i   (act_q),
    .free_idx_o (free_idx),
    .any_free_o (any_free)
  );

  // Out-of-range indices match no bit; inactive bits clear to no effect.
  always_comb begin
    kill_m = '0;
    set_m  = '0;
    for (int i = 0; i < MAX_ENEMIES; i++) begin
      kill_m[i] = kill_valid && (kill_idx == SLOT_W'(i));
      set_m[i]  = (state_q == SELECT) && (slot_q == SLOT_W'(i));
    end
    act_d = (act_q & ~kill_m) | set_m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= PER_W'(START_PERIOD);
      frame_q  <= '0;
      ramp_q   <= '0;
      due_q    <= 1'b0;
      last_q   <= '0;
      angle_q  <= '0;
      slot_q   <= '0;
      valid_q  <= 1'b0;
      sslot_q  <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      act_q    <= '0;
    end else if (!game_active) begin
      state_q  <= IDLE;
      period_q <= PER_W'(START_PERIOD);
      frame_q  <= '0;
      ramp_q   <= '0;
      due_q    <= 1'b0;
      last_q   <= '0;
      angle_q  <= '0;
      slot_q   <= '0;
      valid_q  <= 1'b0;
      sslot_q  <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      act_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      act_q   <= act_d;
      unique case (state_q)
        IDLE: state_q <= WAIT;
        WAIT: begin
          if (due_q && any_free) begin
            state_q <= SELECT;
            angle_q <= next_angle(rand_angle, last_q);
            slot_q  <= free_idx;
            due_q   <= 1'b0;
            frame_q <= '0;
          end else if (frame_tick) begin
            if (frame_q == period_q - PER_W'(1)) due_q <= 1'b1;
            else frame_q <= frame_q + PER_W'(1);
          end
        end
        SELECT: begin
          state_q <= ISSUE;
          valid_q <= 1'b1;
          sslot_q <= slot_q;
          sx_q    <= lut_x;
          sy_q    <= lut_y;
          last_q  <= angle_q;
          if (ramp_q == PER_W'(RAMP_SPAWNS - 1)) begin
            ramp_q <= '0;
            if (period_q > PER_W'(MIN_PERIOD))
              period_q <= period_q - PER_W'(1);
          end else begin
            ramp_q <= ramp_q + PER_W'(1);
          end
        end
        ISSUE: state_q <= WAIT;
      endcase
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < MAX_ENEMIES; i++)
      active_count = active_count + CNT_W'(act_q[i]);
  end

  assign angle_sel   = angle_q;
  assign spawn_valid = valid_q;
  assign spawn_slot  = sslot_q;
  assign spawn_x     = sx_q;
  assign spawn_y     = sy_q;
  assign slot_active = act_q;
endmodule
